dprf: RTL and testbench
=======================

// Module: dprf
// PURPOSE
//  - Dual-read, single-write register file: 16 x 32-bit general registers for the CPU datapath.
//  - The decode stage drives two source selects and reads two operands combinationally.
//  - Writeback writes one register per clock edge when enabled.
// PARAMETERS
//  - DATA_W   32  width of each register and of the data ports
//  - ADDR_W   4   width of every register-select port
//  - NUM_REGS 16  number of registers; must equal 2**ADDR_W
// PORTS
//  - clk             in   1       single clock; all writes occur on its rising edge
//  - reset           in   1       asynchronous, active-low reset (0 = in reset)
//  - we              in   1       write enable, sampled at the clk rising edge
//  - regsel_dest     in   ADDR_W  index of the register written when we=1
//  - regsel_source0  in   ADDR_W  index read onto dataout0
//  - regsel_source1  in   ADDR_W  index read onto dataout1
//  - datain          in   DATA_W  write data
//  - dataout0        out  DATA_W  contents of register[regsel_source0]
//  - dataout1        out  DATA_W  contents of register[regsel_source1]
// BEHAVIOUR
//  - Reset:
//    - While reset=0, all NUM_REGS registers are forced to 0 immediately, without waiting for clk.
//    - dataout0 and dataout1 therefore read 0.
//    - Writes are ignored while reset=0.
//  - Write:
//    - At posedge clk with reset=1 and we=1, register[regsel_dest] <= datain.
//    - Write latency is 1 edge.
//    - With we=0, no register changes, regardless of regsel_dest or datain.
//  - Read:
//    - Purely combinational; zero-cycle latency.
//    - dataoutN follows regsel_sourceN and the register contents within the same cycle.
//    - Reads are independent; both ports may select the same register.
//  - Register 0 is an ordinary writable register (no hardwired zero).
//  - Read/write collision (same index, same cycle):
//    - Without DPRF_BYPASS_EN: the read returns the old value until the edge, then the new value.
//  - Reset deasserting mid-operation:
//    - Takes effect asynchronously.
//    - The first write is accepted at the first posedge clk where reset=1.
//  - All selects are full-range; there are no out-of-range indices.
//  - No X on outputs after reset.
// CONFIGURATION
//  - Macro DPRF_BYPASS_EN:
//    - Defined: when reset=1, we=1 and regsel_dest==regsel_sourceN, dataoutN = datain combinationally (write-through forwarding).
//    - Undefined: outputs always show stored register contents.
//  - The default build leaves DPRF_BYPASS_EN undefined.
// STRUCTURE
//  - Package dprf_pkg:
//    - DATA_W, ADDR_W, NUM_REGS constants
//    - typedefs reg_data_t (logic [DATA_W-1:0]) and reg_sel_t (logic [ADDR_W-1:0])
//  - Sub-module dprf_read_port, instantiated twice (port 0 and port 1):
//    - Inputs: register array, select, and (when DPRF_BYPASS_EN) we/regsel_dest/datain.
//    - Output: the selected data.
//  - Top: the storage array with async-clear write logic plus the two read-port instances.
// TESTING
//  - Reset: hold reset=0 for 3 clks, read selects 0/15 -> dataout0=0, dataout1=0. Pulse reset=0 mid-run -> all regs read 0 at once.
//  - Write/read: reset=1, we=1, regsel_dest=3, datain=30, 1 edge, we=0; regsel_source0=3 -> dataout0=30.
//  - Disabled write: we=0, regsel_dest=10, datain=100 for 10 edges; regsel_source1=10 -> dataout1=0, and register 3 still reads 30.
//  - Dual read: write r5=0xDEADBEEF, r12=0x12345678; sources 5/12 -> both outputs correct in the same cycle. Sources 5/5 -> both 0xDEADBEEF.
//  - Collision: we=1, dest=7, source0=7, datain=55, r7 previously 9.
//    - Without DPRF_BYPASS_EN: dataout0=9 before the edge, 55 after.
//    - With DPRF_BYPASS_EN: dataout0=55 before the edge.
//  - Sweep: write r[i]=i*17 for i=0..15, then read all 16 on both ports -> each matches, r0=0.

Source files
------------

// File: rtl/dprf_pkg.sv
// Shared constants and types for the dual-read, single-write register file.
// Optional build macro DPRF_BYPASS_EN enables write-through forwarding on reads.
package dprf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  // Derived so the select range always covers the array exactly.
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_sel_t;
  typedef reg_data_t [NUM_REGS-1:0] reg_array_t;
endpackage

// File: rtl/dprf_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// There is no handshake: a write with we=1 commits at the next rising clk; reads have zero latency.
interface dprf_if;
  import dprf_pkg::*;

  logic      we;
  reg_sel_t  regsel_dest;
  reg_sel_t  regsel_source0;
  reg_sel_t  regsel_source1;
  reg_data_t datain;
  reg_data_t dataout0;
  reg_data_t dataout1;

  modport master (
    output we, regsel_dest, regsel_source0, regsel_source1, datain,
    input  dataout0, dataout1
  );

  modport slave (
    input  we, regsel_dest, regsel_source0, regsel_source1, datain,
    output dataout0, dataout1
  );
endinterface

// File: rtl/dprf_read_port.sv
// One combinational read port: selects a register, optionally forwarding same-cycle write data.
// Forwarding is compiled in only when DPRF_BYPASS_EN is defined.
module dprf_read_port
  import dprf_pkg::*;
(
  input  reg_array_t regs,
  input  reg_sel_t   sel,
`ifdef DPRF_BYPASS_EN
  input  logic       wr_en,
  input  reg_sel_t   wr_sel,
  input  reg_data_t  wr_data,
`endif
  output reg_data_t  data
);

  always_comb begin
    data = regs[sel];
`ifdef DPRF_BYPASS_EN
    if (wr_en && (wr_sel == sel)) begin
      data = wr_data;
    end
`else
    data = data;
`endif
  end

endmodule

// File: rtl/dprf.sv
// 16 x 32 register file with async active-low clear, one write port and two read ports.
// Build macro DPRF_BYPASS_EN turns on write-through forwarding to the read ports.
module dprf
  import dprf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  dprf_if.slave bus
);

  reg_array_t regs;
  reg_data_t  rd0;
  reg_data_t  rd1;

  // Clear is asynchronous so outputs read zero the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (bus.we) begin
      regs[bus.regsel_dest] <= bus.datain;
    end
  end

`ifdef DPRF_BYPASS_EN
  logic wr_en;
  assign wr_en = bus.we & reset;

  dprf_read_port u_read0 (
    .regs    (regs),
    .sel     (bus.regsel_source0),
    .wr_en   (wr_en),
    .wr_sel  (bus.regsel_dest),
    .wr_data (bus.datain),
    .data    (rd0)
  );

  dprf_read_port u_read1 (
    .regs    (regs),
    .sel     (bus.regsel_source1),
    .wr_en   (wr_en),
    .wr_sel  (bus.regsel_dest),
    .wr_data (bus.datain),
    .data    (rd1)
  );
`else
  dprf_read_port u_read0 (
    .regs (regs),
    .sel  (bus.regsel_source0),
    .data (rd0)
  );

  dprf_read_port u_read1 (
    .regs (regs),
    .sel  (bus.regsel_source1),
    .data (rd1)
  );
`endif

  assign bus.dataout0 = rd0;
  assign bus.dataout1 = rd1;

endmodule

// File: tb/tb_dprf.sv
// Directed self-checking bench for the dprf register file.
// Collision expectations follow DPRF_BYPASS_EN when the bench is built with it.
module tb_dprf;
  import dprf_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dprf_if bus ();

  dprf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input reg_sel_t a, input reg_data_t d);
    @(negedge clk);
    bus.we          = 1'b1;
    bus.regsel_dest = a;
    bus.datain      = d;
    @(negedge clk);
    bus.we          = 1'b0;
  endtask

  task automatic rd(input reg_sel_t s0, input reg_sel_t s1);
    bus.regsel_source0 = s0;
    bus.regsel_source1 = s1;
    #1;
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    reset              = 1'b0;
    bus.we             = 1'b1;
    bus.regsel_dest    = 4'd3;
    bus.datain         = 32'hFFFF_FFFF;
    bus.regsel_source0 = 4'd0;
    bus.regsel_source1 = 4'd15;

    // Reset held for 3 clocks with a write attempted throughout
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd(4'd0, 4'd15);
    check_eq("reset_r0", bus.dataout0, 32'd0);
    check_eq("reset_r15", bus.dataout1, 32'd0);
    rd(4'd3, 4'd3);
    check_eq("reset_write_ignored", bus.dataout0, 32'd0);
    bus.we = 1'b0;
    reset  = 1'b1;

    // Basic write then read
    wr(4'd3, 32'd30);
    rd(4'd3, 4'd0);
    check_eq("write_r3", bus.dataout0, 32'd30);

    // Disabled write held for 10 edges
    bus.we          = 1'b0;
    bus.regsel_dest = 4'd10;
    bus.datain      = 32'd100;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rd(4'd3, 4'd10);
    check_eq("we0_r10", bus.dataout1, 32'd0);
    check_eq("we0_r3_kept", bus.dataout0, 32'd30);

    // Dual read
    wr(4'd5, 32'hDEAD_BEEF);
    wr(4'd12, 32'h1234_5678);
    rd(4'd5, 4'd12);
    check_eq("dual_p0_r5", bus.dataout0, 32'hDEAD_BEEF);
    check_eq("dual_p1_r12", bus.dataout1, 32'h1234_5678);
    rd(4'd5, 4'd5);
    check_eq("same_p0_r5", bus.dataout0, 32'hDEAD_BEEF);
    check_eq("same_p1_r5", bus.dataout1, 32'hDEAD_BEEF);

    // Collision: r7 = 9, then write 55 while reading r7
    wr(4'd7, 32'd9);
    rd(4'd7, 4'd3);
    check_eq("coll_pre_value", bus.dataout0, 32'd9);
    bus.we          = 1'b1;
    bus.regsel_dest = 4'd7;
    bus.datain      = 32'd55;
    #1;
`ifdef DPRF_BYPASS_EN
    check_eq("coll_before_edge", bus.dataout0, 32'd55);
`else
    check_eq("coll_before_edge", bus.dataout0, 32'd9);
`endif
    check_eq("coll_other_port", bus.dataout1, 32'd30);
    @(posedge clk);
    #1;
    check_eq("coll_after_edge", bus.dataout0, 32'd55);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    check_eq("coll_settled", bus.dataout0, 32'd55);

    // Mid-run async reset pulse, with a write pending across an edge
    rd(4'd3, 4'd5);
    #2;
    reset           = 1'b0;
    #1;
    check_eq("pulse_r3_cleared", bus.dataout0, 32'd0);
    check_eq("pulse_r5_cleared", bus.dataout1, 32'd0);
    bus.we          = 1'b1;
    bus.regsel_dest = 4'd4;
    bus.datain      = 32'd77;
    @(posedge clk);
    #1;
    rd(4'd4, 4'd12);
    check_eq("pulse_write_ignored", bus.dataout0, 32'd0);
    check_eq("pulse_r12_cleared", bus.dataout1, 32'd0);
    // Release mid-cycle: the very next edge must accept the write
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("first_write_after_reset", bus.dataout0, 32'd77);
    @(negedge clk);
    bus.we = 1'b0;

    // Sweep all registers
    for (int i = 0; i < 16; i++) begin
      wr(reg_sel_t'(i), reg_data_t'(i * 17));
    end
    for (int i = 0; i < 16; i++) begin
      rd(reg_sel_t'(i), reg_sel_t'(15 - i));
      check_eq($sformatf("sweep_p0_r%0d", i), bus.dataout0, 32'(i * 17));
      check_eq($sformatf("sweep_p1_r%0d", 15 - i), bus.dataout1, 32'((15 - i) * 17));
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
